// File: rtl/alu_gen2.sv
// Registered ALU with single-cycle arithmetic/logic/compare/shift ops and an
// optional WIDTH-cycle restoring divider enabled by macro ALU_GEN2_DIV_EN.
module alu_gen2 #(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALU_FUN,
   output logic             OUT_VALID,
   output logic [WIDTH-1:0] ALU_OUT,
   output logic             Arith_Flag,
   output logic             Logic_Flag,
   output logic             CMP_Flag,
   output logic             Shift_Flag,
   output logic             DIV_ERR
);

   // state    | meaning
   // IDLE     | ready; single-cycle ops complete at the accept edge
   // DIV_BUSY | divider iterating, requests ignored
   typedef enum logic [0:0] {IDLE, DIV_BUSY} state_t;

   state_t           state, state_nxt;
   logic             accept;
   logic             div_start;
   logic             div_done;
   logic [WIDTH-1:0] div_quo;
   logic [WIDTH-1:0] res;
   logic [3:0]       flags;
   logic             err;

   assign accept = IN_VALID & IN_READY;

   always_comb begin
      res       = '0;
      flags     = 4'b0000;
      err       = 1'b0;
      div_start = 1'b0;
      case (ALU_FUN)
         4'b0000: begin res = A + B;  flags = 4'b1000; end
         4'b0001: begin res = A - B;  flags = 4'b1000; end
         4'b0010: begin res = A * B;  flags = 4'b1000; end
`ifdef ALU_GEN2_DIV_EN
         4'b0011: begin
            flags = 4'b1000;
            if (B == '0) begin
               res = '1;
               err = 1'b1;
            end else begin
               div_start = 1'b1;
            end
         end
`endif
         4'b0100: begin res = A & B;     flags = 4'b0100; end
         4'b0101: begin res = A | B;     flags = 4'b0100; end
         4'b0110: begin res = ~(A & B);  flags = 4'b0100; end
         4'b0111: begin res = ~(A | B);  flags = 4'b0100; end
         4'b1000: begin res = A ^ B;     flags = 4'b0100; end
         4'b1001: begin res = ~(A ^ B);  flags = 4'b0100; end
         4'b1010: begin res = (A == B) ? WIDTH'(1) : '0; flags = 4'b0010; end
         4'b1011: begin res = (A > B)  ? WIDTH'(2) : '0; flags = 4'b0010; end
         4'b1100: begin res = (A < B)  ? WIDTH'(3) : '0; flags = 4'b0010; end
         4'b1101: begin res = A >> 1;    flags = 4'b0001; end
         4'b1110: begin res = A << 1;    flags = 4'b0001; end
         default: begin res = '0;        flags = 4'b0000; end
      endcase
   end

`ifdef ALU_GEN2_DIV_EN
   localparam int CNT_W = $clog2(WIDTH);

   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] quo, quo_nxt;
   logic [WIDTH-1:0] rem, rem_nxt;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   trial;

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      rem_sh  = {rem, quo[WIDTH-1]};
      trial   = rem_sh - {1'b0, dvs};
      quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH]};
      rem_nxt = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cnt <= '0;
         quo <= '0;
         rem <= '0;
         dvs <= '0;
      end else if (accept && div_start) begin
         cnt <= CNT_W'(WIDTH - 1);
         quo <= A;
         rem <= '0;
         dvs <= B;
      end else if (state == DIV_BUSY) begin
         quo <= quo_nxt;
         rem <= rem_nxt;
         if (cnt != '0) cnt <= cnt - 1'b1;
      end
   end

   assign div_done = (state == DIV_BUSY) && (cnt == '0);
   assign div_quo  = quo_nxt;
`else
   assign div_done = 1'b0;
   assign div_quo  = '0;
`endif

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      IN_READY  = (state == IDLE);
      case (state)
         IDLE:     if (accept && div_start) state_nxt = DIV_BUSY;
         DIV_BUSY: if (div_done)            state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         OUT_VALID  <= 1'b0;
         ALU_OUT    <= '0;
         Arith_Flag <= 1'b0;
         Logic_Flag <= 1'b0;
         CMP_Flag   <= 1'b0;
         Shift_Flag <= 1'b0;
         DIV_ERR    <= 1'b0;
      end else if (accept && !div_start) begin
         OUT_VALID  <= 1'b1;
         ALU_OUT    <= res;
         {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag} <= flags;
         DIV_ERR    <= err;
      end else if (div_done) begin
         OUT_VALID  <= 1'b1;
         ALU_OUT    <= div_quo;
         {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag} <= 4'b1000;
         DIV_ERR    <= 1'b0;
      end else begin
         OUT_VALID  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_gen2.sv
// Directed bench for alu_gen2: a WIDTH=16 instance plus a WIDTH=8 instance for
// narrow shift wrap; divide checks follow whichever ALU_GEN2_DIV_EN build is used.
module tb_alu_gen2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic [3:0]  fun = '0;

   logic        in_ready, out_valid, f_ar, f_lo, f_cm, f_sh, div_err;
   logic [15:0] alu_out;
   logic        in_ready8, out_valid8, f_ar8, f_lo8, f_cm8, f_sh8, div_err8;
   logic [7:0]  alu_out8;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   alu_gen2 #(.WIDTH(16)) dut (
      .CLK(clk), .RST(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
      .A(a), .B(b), .ALU_FUN(fun), .OUT_VALID(out_valid), .ALU_OUT(alu_out),
      .Arith_Flag(f_ar), .Logic_Flag(f_lo), .CMP_Flag(f_cm), .Shift_Flag(f_sh),
      .DIV_ERR(div_err)
   );

   alu_gen2 #(.WIDTH(8)) dut8 (
      .CLK(clk), .RST(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready8),
      .A(a[7:0]), .B(b[7:0]), .ALU_FUN(fun), .OUT_VALID(out_valid8), .ALU_OUT(alu_out8),
      .Arith_Flag(f_ar8), .Logic_Flag(f_lo8), .CMP_Flag(f_cm8), .Shift_Flag(f_sh8),
      .DIV_ERR(div_err8)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one request for one edge, then sample just after that edge.
   task automatic do_op(input logic [3:0] f, input logic [15:0] va, input logic [15:0] vb);
      fun      = f;
      a        = va;
      b        = vb;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic check_res(input string tag, input logic [15:0] val, input logic [3:0] flg, input logic err);
      check_val({tag, "_valid"}, out_valid, 1'b1);
      check_val({tag, "_out"},   alu_out, val);
      check_val({tag, "_flags"}, {f_ar, f_lo, f_cm, f_sh}, flg);
      check_val({tag, "_err"},   div_err, err);
   endtask

   typedef struct {
      string       tag;
      logic [3:0]  f;
      logic [15:0] va;
      logic [15:0] vb;
      logic [15:0] res;
      logic [3:0]  flg;
   } vec_t;

   vec_t vecs[$];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs.push_back('{"mul",  4'b0010, 16'h0123, 16'h0100, 16'h2300, 4'b1000});
      vecs.push_back('{"and",  4'b0100, 16'hAB02, 16'hF523, 16'hA102, 4'b0100});
      vecs.push_back('{"or",   4'b0101, 16'h00F0, 16'h0F00, 16'h0FF0, 4'b0100});
      vecs.push_back('{"nor",  4'b0111, 16'h00F0, 16'h0F00, 16'hF00F, 4'b0100});
      vecs.push_back('{"xor",  4'b1000, 16'hFF00, 16'h0FF0, 16'hF0F0, 4'b0100});
      vecs.push_back('{"xnor", 4'b1001, 16'hFF00, 16'h0FF0, 16'h0F0F, 4'b0100});
      vecs.push_back('{"eq_t", 4'b1010, 16'd7,    16'd7,    16'd1,    4'b0010});
      vecs.push_back('{"eq_f", 4'b1010, 16'd7,    16'd8,    16'd0,    4'b0010});
      vecs.push_back('{"gt_t", 4'b1011, 16'd9,    16'd3,    16'd2,    4'b0010});
      vecs.push_back('{"lt_f", 4'b1100, 16'd9,    16'd3,    16'd0,    4'b0010});
      vecs.push_back('{"lt_t", 4'b1100, 16'd3,    16'd9,    16'd3,    4'b0010});
      vecs.push_back('{"add_w",4'b0000, 16'hFFFF, 16'h0002, 16'h0001, 4'b1000});
      vecs.push_back('{"shr",  4'b1101, 16'h80F1, 16'h0000, 16'h4078, 4'b0001});
      vecs.push_back('{"shl",  4'b1110, 16'h80F1, 16'h0000, 16'h01E2, 4'b0001});
      vecs.push_back('{"undef",4'b1111, 16'h80F1, 16'h1234, 16'h0000, 4'b0000});

      #2;
      check_val("rst_out",   alu_out, 16'h0000);
      check_val("rst_valid", out_valid, 1'b0);
      check_val("rst_flags", {f_ar, f_lo, f_cm, f_sh, div_err}, 5'b00000);
      check_val("rst_ready", in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      do_op(4'b0000, 16'd25, 16'd40);
      check_res("add", 16'd65, 4'b1000, 1'b0);
      @(posedge clk); #1;
      check_val("idle_valid", out_valid, 1'b0);
      check_val("hold_out",   alu_out, 16'd65);
      check_val("hold_flags", {f_ar, f_lo, f_cm, f_sh}, 4'b1000);

      do_op(4'b0001, 16'd50, 16'd66);
      check_res("sub_b2b", 16'hFFF0, 4'b1000, 1'b0);
      do_op(4'b0110, 16'hAB02, 16'hF523);
      check_res("nand_b2b", 16'h5EFD, 4'b0100, 1'b0);

      foreach (vecs[i]) begin
         do_op(vecs[i].f, vecs[i].va, vecs[i].vb);
         check_res(vecs[i].tag, vecs[i].res, vecs[i].flg, 1'b0);
      end

      do_op(4'b1101, 16'h00F1, 16'h0000);
      check_val("w8_shr", alu_out8, 8'h78);
      check_val("w8_shr_flags", {f_ar8, f_lo8, f_cm8, f_sh8}, 4'b0001);
      do_op(4'b1110, 16'h00F1, 16'h0000);
      check_val("w8_shl", alu_out8, 8'hE2);
      do_op(4'b1111, 16'h00F1, 16'h0000);
      check_val("w8_undef", alu_out8, 8'h00);
      check_val("w8_undef_flags", {f_ar8, f_lo8, f_cm8, f_sh8, div_err8}, 5'b00000);

`ifdef ALU_GEN2_DIV_EN
      begin
         int busy_low = 0;
         int early_valid = 0;
         do_op(4'b0011, 16'd66, 16'd5);
         if (!in_ready) busy_low++;
         for (int i = 1; i < 16; i++) begin
            if (i % 4 == 1) begin
               fun = 4'b0000; a = 16'd1; b = 16'd1; in_valid = 1'b1;
            end else begin
               fun = 4'b0011; a = 16'hFFFF; b = 16'd0; in_valid = 1'b0;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (!in_ready) busy_low++;
            if (out_valid) early_valid++;
         end
         check_val("div_busy_cycles", busy_low, 16);
         check_val("div_early_valid", early_valid, 0);
         @(posedge clk); #1;
         check_res("div", 16'd13, 4'b1000, 1'b0);
         check_val("div_ready_after", in_ready, 1'b1);
         @(posedge clk); #1;
         check_val("div_valid_pulse", out_valid, 1'b0);
      end

      do_op(4'b0011, 16'd60, 16'd0);
      check_res("div0", 16'hFFFF, 4'b1000, 1'b1);
      check_val("div0_ready", in_ready, 1'b1);
      do_op(4'b0000, 16'd1, 16'd1);
      check_res("err_clear", 16'd2, 4'b1000, 1'b0);

      begin
         int stray = 0;
         do_op(4'b0011, 16'd1000, 16'd7);
         repeat (5) @(posedge clk);
         #1;
         rst_n = 1'b0;
         #1;
         check_val("abort_out",   alu_out, 16'h0000);
         check_val("abort_ready", in_ready, 1'b1);
         check_val("abort_flags", {out_valid, f_ar, f_lo, f_cm, f_sh, div_err}, 6'b000000);
         @(negedge clk);
         rst_n = 1'b1;
         repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) stray++;
         end
         check_val("abort_no_valid", stray, 0);
      end
`else
      do_op(4'b0011, 16'd60, 16'd5);
      check_res("nodiv", 16'h0000, 4'b0000, 1'b0);
      check_val("nodiv_ready", in_ready, 1'b1);
      do_op(4'b0011, 16'd60, 16'd0);
      check_res("nodiv_b0", 16'h0000, 4'b0000, 1'b0);
`endif

      do_op(4'b0000, 16'd25, 16'd40);
      check_val("pre_rst_out", alu_out, 16'd65);
      #3;
      rst_n = 1'b0;
      #1;
      check_val("async_rst_out", alu_out, 16'h0000);
      check_val("async_rst_flags", {out_valid, f_ar, f_lo, f_cm, f_sh, div_err}, 6'b000000);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(4'b0101, 16'h1000, 16'h0001);
      check_res("first_after_rst", 16'h1001, 4'b0100, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
